// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches a whole block from main memory, streams each word into
// the data array, then pulses the tag write one cycle after the last data write.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int OFFSET_BITS     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic [15:0]           memory_data,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  memory_read_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] cache_fill_addr,
    output logic [15:0]           cache_fill_data,
    output logic                  write_tag_array
);

    localparam int IW = $clog2(WORDS_PER_BLOCK);
    localparam int CW = IW + 1;
    localparam int BW = ADDR_WIDTH - OFFSET_BITS;
    localparam logic [CW-1:0] FULL = CW'(WORDS_PER_BLOCK);
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

    state_t          state;
    logic [BW-1:0]   blk;
    logic [CW-1:0]   req_cnt;
    logic [CW-1:0]   rcv_cnt;
    logic [CW-1:0]   req_nxt;
    logic            unused_offset;

    assign req_nxt       = req_cnt + CW'(1);
    assign unused_offset = ^miss_address[OFFSET_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            blk             <= '0;
            req_cnt         <= '0;
            rcv_cnt         <= '0;
            fsm_busy        <= 1'b0;
            memory_read_en  <= 1'b0;
            memory_address  <= '0;
            write_tag_array <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    write_tag_array <= 1'b0;
                    if (miss_detected) begin
                        blk            <= miss_address[ADDR_WIDTH-1:OFFSET_BITS];
                        req_cnt        <= '0;
                        rcv_cnt        <= '0;
                        fsm_busy       <= 1'b1;
                        memory_read_en <= 1'b1;
                        memory_address <= {miss_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        state          <= FILL;
                    end
                end
                FILL: begin
                    // Outputs are registered, so the next request is prepared one edge ahead.
                    if (req_cnt < FULL) begin
                        req_cnt        <= req_nxt;
                        memory_read_en <= (req_nxt < FULL);
                        memory_address <= {blk, req_nxt[IW-1:0], 1'b0};
                    end
                    if (memory_data_valid) begin
                        rcv_cnt <= rcv_cnt + CW'(1);
                        if (rcv_cnt == LAST) begin
                            memory_read_en  <= 1'b0;
                            write_tag_array <= 1'b1;
                            state           <= TAG;
                        end
                    end
                end
                TAG: begin
                    write_tag_array <= 1'b0;
                    fsm_busy        <= 1'b0;
                    memory_address  <= '0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data writes follow the memory valid directly; the tag write lands one cycle later.
    assign write_data_array = (state == FILL) && memory_data_valid;
    assign cache_fill_data  = memory_data;

    always_comb begin
        cache_fill_addr = '0;
        if (state == FILL)
            cache_fill_addr = {blk, rcv_cnt[IW-1:0], 1'b0};
        else if (state == TAG)
            cache_fill_addr = {blk, {OFFSET_BITS{1'b0}}};
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler on the memory side of the 2-way set-associative cache: 64 sets, 16-byte blocks of 8 x 16-bit words.
- On a cache miss, fetches the whole block from multi-cycle main memory with one pipelined read request per cycle.
- Streams each returned word into the cache data array, then pulses the tag-array write. That pulse clears the cache's miss latch and updates LRU.
- One instance per cache (I-cache and D-cache), between the cache and the memory arbiter.

Parameters:
ADDR_WIDTH, 16, byte address width.
WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two.
OFFSET_BITS, 4, byte-offset bits per block; equals log2(WORDS_PER_BLOCK*2).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
miss_detected  input  1  cache reports a miss on miss_address.
miss_address  input  ADDR_WIDTH  address that missed.
memory_data  input  16  read data returned by memory.
memory_data_valid  input  1  memory_data is valid this cycle.
fsm_busy  output  1  fill in progress; pipeline stalls while high.
memory_read_en  output  1  issue a memory read at memory_address this cycle.
memory_address  output  ADDR_WIDTH  word address of the current read request.
write_data_array  output  1  write memory_data into the cache data array this cycle.
cache_fill_addr  output  ADDR_WIDTH  cache address for the current data-array write.
cache_fill_data  output  16  data for the data-array write; combinational pass-through of memory_data.
write_tag_array  output  1  one-cycle pulse that writes the tag, valid and LRU bits.

Behaviour:
- Reset is asynchronous and active-high; reset values:
  - state = IDLE.
  - req_cnt and rcv_cnt = 0.
  - Latched base address = 0.
  - All outputs 0, except cache_fill_data, which is a pure pass-through.
- States and transitions:
  - IDLE: fsm_busy=0; memory_read_en, write_data_array and write_tag_array all 0. On miss_detected=1 at a rising edge:
    - latch base = {miss_address[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'b0};
    - clear both counters;
    - go to FILL.
  - FILL: fsm_busy=1.
    - Requests: memory_read_en=1 while req_cnt < WORDS_PER_BLOCK, with memory_address = base + 2*req_cnt. req_cnt increments each cycle until it saturates at WORDS_PER_BLOCK; then memory_read_en=0.
    - Returns: on memory_data_valid=1, write_data_array=1, cache_fill_addr = base + 2*rcv_cnt, rcv_cnt increments.
    - When the valid word with rcv_cnt == WORDS_PER_BLOCK-1 arrives, go to TAG.
  - TAG: fsm_busy=1, write_tag_array=1 for exactly this cycle, cache_fill_addr = base, write_data_array=0. Go to IDLE next cycle.
    - The tag write is deliberately one cycle after the last data write, so way selection stays stable for every data-array write.
- Address arithmetic:
  - Offsets wrap modulo the block, i.e. only the low OFFSET_BITS change; the upper address bits stay equal to base.
  - memory_address bit 0 is always 0.
- Latency:
  - Miss sampled at edge 0; first request in cycle 1; last request in cycle WORDS_PER_BLOCK.
  - With memory latency L, the last data write is in cycle WORDS_PER_BLOCK+L and the tag pulse is in the following cycle.
- Boundary conditions:
  - miss_detected while fsm_busy=1: ignored; the latched base is not modified.
  - memory_data_valid in IDLE or TAG: ignored; no writes.
  - memory_data_valid with memory_read_en=1 in the same cycle: both are serviced.
  - Extra valid after WORDS_PER_BLOCK words are received: cannot occur, because the FSM is already in TAG or IDLE.
  - miss_detected still high in the cycle after TAG, because the cache miss latch has not yet cleared: a new fill starts only if miss_detected=1 while in IDLE. The cache clears its latch on write_tag_array, so no spurious refill occurs.
  - Reset asserted mid-fill: immediately IDLE with all outputs 0; a partial block is not tag-written, so the block stays invalid.
- Width rules: counters are log2(WORDS_PER_BLOCK)+1 bits wide and never wrap.

Test Plan:
- Basic fill, memory latency 4: miss_address=16'h1A36 -> memory_address 16'h1A30, 32, ..., 3E in cycles 1-8; write_data_array in cycles 5-12 with cache_fill_addr 16'h1A30..1A3E matching the data order; write_tag_array=1 only in cycle 13; fsm_busy cycles 1-13; IDLE at cycle 14.
- Bursty returns: valid pattern 1,0,1,1,0,0,1,... with 8 valid words -> exactly 8 data writes at consecutive word offsets; tag pulse the cycle after the 8th; no extra memory_read_en after 8 requests.
- Spurious inputs: memory_data_valid=1 in IDLE, and miss_detected toggled with miss_address=16'hFFFE during FILL -> no writes in IDLE; base stays at the original block; all fill addresses are in the original block.
- Reset mid-fill: assert rst after the 3rd data write -> all outputs 0 asynchronously (before the next edge); no write_tag_array; a new miss at 16'h0004 then fills block 16'h0000-000E normally.
- Back-to-back misses: miss held high through the tag cycle, then a new miss at 16'hC0F0 in IDLE -> second fill starts the cycle after the miss is sampled in IDLE; tag pulses are exactly one per fill.
- Top address block: miss_address=16'hFFF2 -> memory_address 16'hFFF0..FFFE with no overflow into 16'h0000.
